// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: B-type funct3 codes, 2-bit
// bimodal counter encodings and the counter update rule.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] BHT_RESET = CTR_WNT;

  // Saturating step toward the observed direction; the extremes hold.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) nxt = ctr + 2'b01;
    if (!taken && (ctr != CTR_SNT)) nxt = ctr - 2'b01;
    return nxt;
  endfunction

  // 010 and 011 are the two funct3 codes with no B-type meaning.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Bimodal branch history table: one combinational read port for fetch and
// one synchronous saturating update port for the resolving branch.
module branch_bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  logic [1:0] r_ctr [ENTRIES];

  // Read sees the stored value only: a same-cycle update is not bypassed.
  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= BHT_RESET;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decides direction from branch_comp results,
// checks the fetch prediction, raises a registered redirect/flush and trains the BHT.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            brun,
  input  logic            breq,
  input  logic            brlt,
  output logic            ex_taken,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_if_ctr;
  logic             w_dir;
  logic             w_legal;
  logic             w_resolve;
  logic             w_mispred;
  logic [PC_W-1:0]  w_fallthru;

  logic             r_redirect;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispred_cnt;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];

  branch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (w_if_idx),
    .o_rd_ctr    (w_if_ctr),
    .i_upd_en    (w_resolve),
    .i_upd_idx   (w_ex_idx),
    .i_upd_taken (ex_taken)
  );

  assign pred_taken = w_if_ctr[1];
  assign brun       = ex_funct3[1];

  always_comb begin
    w_dir = 1'b0;
    case (ex_funct3)
      F3_BEQ:           w_dir = breq;
      F3_BNE:           w_dir = ~breq;
      F3_BLT, F3_BLTU:  w_dir = brlt;
      F3_BGE, F3_BGEU:  w_dir = ~brlt;
      default:          w_dir = 1'b0;
    endcase
  end

  assign w_legal    = f3_legal(ex_funct3);
  assign ex_taken   = ex_valid & ex_is_branch & w_legal & w_dir;
  assign w_resolve  = ex_valid & ex_is_branch & w_legal & ~ex_stall;
  assign w_mispred  = w_resolve & (ex_taken != ex_pred_taken);
  assign w_fallthru = ex_pc + PC_W'(4);

  // redirect_pc holds its last value between pulses; only redirect qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_redirect <= w_mispred;
      if (w_mispred) begin
        r_redirect_pc <= ex_taken ? ex_target : w_fallthru;
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
      if (w_resolve) r_branch_cnt <= r_branch_cnt + 32'd1;
    end
  end

  assign redirect    = r_redirect;
  assign flush       = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized branches
// checked against an operand-level reference model of direction, BHT and counters.
module tb_branch_resolve_unit;

  localparam int N    = 16;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PC_W-1:0] if_pc = '0;
  logic            pred_taken;
  logic            ex_valid = 1'b0;
  logic            ex_stall = 1'b0;
  logic            ex_is_branch = 1'b0;
  logic [2:0]      ex_funct3 = 3'b000;
  logic [PC_W-1:0] ex_pc = '0;
  logic [PC_W-1:0] ex_target = '0;
  logic            ex_pred_taken = 1'b0;
  logic            brun;
  logic            breq = 1'b0;
  logic            brlt = 1'b0;
  logic            ex_taken;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int              m_bht [N];
  logic [31:0]     m_bcnt;
  logic [31:0]     m_mcnt;
  logic            m_redirect;
  logic [PC_W-1:0] m_rpc;
  logic [31:0]     s_a, s_b;

  branch_resolve_unit #(.BHT_ENTRIES(N), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .brun(brun), .breq(breq), .brlt(brlt),
    .ex_taken(ex_taken), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // Architectural meaning of each B-type instruction on its operands.
  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit exp_taken_now();
    return ex_valid && ex_is_branch && ref_taken(ex_funct3, s_a, s_b);
  endfunction

  function automatic bit exp_pred(input logic [PC_W-1:0] pc);
    return m_bht[idx_of(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bht[i] = 1;
    m_bcnt = 0; m_mcnt = 0; m_redirect = 1'b0; m_rpc = '0;
  endtask

  task automatic apply(input logic valid, input logic isb, input logic stall,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input logic pred);
    ex_valid = valid; ex_is_branch = isb; ex_stall = stall; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    s_a = a; s_b = b;
    breq = (a == b);
    brlt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd1, '0, '0, 1'b0);
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit t, res;
    int k;
    @(posedge clk);
    t   = ref_taken(ex_funct3, s_a, s_b);
    res = ex_valid && ex_is_branch && !ex_stall && !(ex_funct3 inside {3'b010, 3'b011});
    m_redirect = 1'b0;
    if (res) begin
      m_bcnt = m_bcnt + 1;
      k = idx_of(ex_pc);
      if (t) begin if (m_bht[k] < 3) m_bht[k]++; end
      else   begin if (m_bht[k] > 0) m_bht[k]--; end
      if (t != ex_pred_taken) begin
        m_mcnt = m_mcnt + 1;
        m_redirect = 1'b1;
        m_rpc = t ? ex_target : ex_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    idle();
    #1;
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%0b exp=0", redirect); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", flush); end
    total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL reset_rpc got=%h exp=%h", redirect_pc, m_rpc); end
    total++; if (branch_cnt !== m_bcnt) begin bad++; $display("FAIL reset_bcnt got=%0d exp=%0d", branch_cnt, m_bcnt); end
    total++; if (mispred_cnt !== m_mcnt) begin bad++; $display("FAIL reset_mcnt got=%0d exp=%0d", mispred_cnt, m_mcnt); end
    for (int i = 0; i < N; i++) begin
      if_pc = {$urandom_range(0, 255), 24'h0} | (i << 2);
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred idx=%0d got=%0b exp=0", i, pred_taken); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq_train();
    apply(1'b1, 1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0);
    #1;
    total++; if (ex_taken !== exp_taken_now()) begin bad++; $display("FAIL beq_taken got=%0b exp=%0b", ex_taken, exp_taken_now()); end
    tick();
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL beq_redirect got=%0b exp=%0b", redirect, m_redirect); end
    total++; if (flush !== m_redirect) begin bad++; $display("FAIL beq_flush got=%0b exp=%0b", flush, m_redirect); end
    total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL beq_rpc got=%h exp=%h", redirect_pc, m_rpc); end
    total++; if (mispred_cnt !== m_mcnt) begin bad++; $display("FAIL beq_mcnt got=%0d exp=%0d", mispred_cnt, m_mcnt); end
    for (int r = 0; r < 2; r++) begin
      apply(1'b1, 1'b1, 1'b0, 3'b000, 32'd9, 32'd9, 32'h100, 32'h140, 1'b1);
      tick();
      total++; if (redirect !== m_redirect) begin bad++; $display("FAIL beq_again_redirect got=%0b exp=%0b", redirect, m_redirect); end
    end
    idle();
    if_pc = 32'h100;
    #1;
    total++; if (pred_taken !== exp_pred(if_pc)) begin bad++; $display("FAIL beq_trained_pred got=%0b exp=%0b", pred_taken, exp_pred(if_pc)); end
    total++; if (branch_cnt !== m_bcnt) begin bad++; $display("FAIL beq_bcnt got=%0d exp=%0d", branch_cnt, m_bcnt); end
  endtask

  task automatic test_bgeu();
    apply(1'b1, 1'b1, 1'b0, 3'b111, 32'd7, 32'd3, 32'h200, 32'h260, 1'b1);
    #1;
    total++; if (brun !== 1'b1) begin bad++; $display("FAIL bgeu_brun got=%0b exp=1", brun); end
    total++; if (ex_taken !== exp_taken_now()) begin bad++; $display("FAIL bgeu_taken got=%0b exp=%0b", ex_taken, exp_taken_now()); end
    tick();
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL bgeu_redirect got=%0b exp=%0b", redirect, m_redirect); end
    total++; if (branch_cnt !== m_bcnt) begin bad++; $display("FAIL bgeu_bcnt got=%0d exp=%0d", branch_cnt, m_bcnt); end
    total++; if (mispred_cnt !== m_mcnt) begin bad++; $display("FAIL bgeu_mcnt got=%0d exp=%0d", mispred_cnt, m_mcnt); end
  endtask

  task automatic test_bne_wrap();
    apply(1'b1, 1'b1, 1'b0, 3'b001, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h0000_2000, 1'b1);
    #1;
    total++; if (brun !== 1'b0) begin bad++; $display("FAIL bne_brun got=%0b exp=0", brun); end
    total++; if (ex_taken !== exp_taken_now()) begin bad++; $display("FAIL bne_taken got=%0b exp=%0b", ex_taken, exp_taken_now()); end
    tick();
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL bne_redirect got=%0b exp=%0b", redirect, m_redirect); end
    total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL bne_wrap_rpc got=%h exp=%h", redirect_pc, m_rpc); end
  endtask

  task automatic test_illegal();
    logic [2:0] f3;
    for (int k = 0; k < 2; k++) begin
      f3 = (k == 0) ? 3'b010 : 3'b011;
      apply(1'b1, 1'b1, 1'b0, f3, 32'd1, 32'd2, 32'h100, 32'h300, 1'b1);
      if_pc = 32'h100;
      #1;
      total++; if (ex_taken !== 1'b0) begin bad++; $display("FAIL illegal_taken f3=%b got=%0b exp=0", f3, ex_taken); end
      tick();
      total++; if (redirect !== m_redirect) begin bad++; $display("FAIL illegal_redirect got=%0b exp=%0b", redirect, m_redirect); end
      total++; if (branch_cnt !== m_bcnt) begin bad++; $display("FAIL illegal_bcnt got=%0d exp=%0d", branch_cnt, m_bcnt); end
      total++; if (pred_taken !== exp_pred(if_pc)) begin bad++; $display("FAIL illegal_bht got=%0b exp=%0b", pred_taken, exp_pred(if_pc)); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 1'b1, 1'b0, 3'b100, 32'd1, 32'd2, 32'h400, 32'h480, 1'b0);
    tick();
    total++; if (redirect_pc !== m_rpc || redirect !== m_redirect) begin bad++; $display("FAIL b2b_first got=%0b/%h exp=%0b/%h", redirect, redirect_pc, m_redirect, m_rpc); end
    apply(1'b1, 1'b1, 1'b0, 3'b101, 32'd1, 32'd2, 32'h500, 32'h580, 1'b1);
    tick();
    total++; if (redirect_pc !== m_rpc || redirect !== m_redirect) begin bad++; $display("FAIL b2b_second got=%0b/%h exp=%0b/%h", redirect, redirect_pc, m_redirect, m_rpc); end
    idle();
    tick();
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL b2b_drop got=%0b exp=%0b", redirect, m_redirect); end
  endtask

  task automatic test_stall_and_reset();
    apply(1'b1, 1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h640, 1'b0);
    #1;
    total++; if (ex_taken !== exp_taken_now()) begin bad++; $display("FAIL stall_taken got=%0b exp=%0b", ex_taken, exp_taken_now()); end
    tick();
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL stall_redirect got=%0b exp=%0b", redirect, m_redirect); end
    total++; if (branch_cnt !== m_bcnt) begin bad++; $display("FAIL stall_bcnt got=%0d exp=%0d", branch_cnt, m_bcnt); end
    ex_stall = 1'b0;
    tick();
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL unstall_redirect got=%0b exp=%0b", redirect, m_redirect); end
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (redirect !== m_redirect) begin bad++; $display("FAIL midreset_redirect got=%0b exp=%0b", redirect, m_redirect); end
    total++; if (mispred_cnt !== m_mcnt) begin bad++; $display("FAIL midreset_mcnt got=%0d exp=%0d", mispred_cnt, m_mcnt); end
    for (int i = 0; i < N; i++) begin
      if_pc = i << 2;
      #1;
      total++; if (pred_taken !== exp_pred(if_pc)) begin bad++; $display("FAIL midreset_pred idx=%0d got=%0b exp=%0b", i, pred_taken, exp_pred(if_pc)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]      f3;
    logic [31:0]     a, b;
    logic [PC_W-1:0] pc;
    for (int n = 0; n < 400; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = {$urandom_range(0, 3) == 0 ? 26'h3FF_FFFF : 26'($urandom), 4'($urandom_range(0, 3)), 2'b00};
      apply($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 5) == 0,
            f3, a, b, pc, $urandom, $urandom_range(0, 1));
      if_pc = $urandom_range(0, 1) ? pc : {$urandom, 2'b00};
      #1;
      total++; if (ex_taken !== exp_taken_now()) begin bad++; $display("FAIL rnd_taken n=%0d got=%0b exp=%0b", n, ex_taken, exp_taken_now()); end
      total++; if (brun !== f3[1]) begin bad++; $display("FAIL rnd_brun n=%0d got=%0b exp=%0b", n, brun, f3[1]); end
      total++; if (pred_taken !== exp_pred(if_pc)) begin bad++; $display("FAIL rnd_pred n=%0d got=%0b exp=%0b", n, pred_taken, exp_pred(if_pc)); end
      tick();
      total++; if (redirect !== m_redirect || flush !== m_redirect) begin bad++; $display("FAIL rnd_redirect n=%0d got=%0b/%0b exp=%0b", n, redirect, flush, m_redirect); end
      if (m_redirect) begin
        total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL rnd_rpc n=%0d got=%h exp=%h", n, redirect_pc, m_rpc); end
      end
      total++; if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin bad++; $display("FAIL rnd_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_beq_train();
    test_bgeu();
    test_bne_wrap();
    test_illegal();
    test_back_to_back();
    test_stall_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
